mips32_fetch_queue: RTL and testbench

//   Instruction prefetch queue directly upstream of the MIPS32 IF/ID stage.
//   - Issues word-address requests to instruction memory and buffers returned words with their NPC.
//   - Presents instruction words to the IF stage in order through a valid/ready handshake.
//   - On a taken-branch redirect: flushes buffered and in-flight words and restarts fetch at the target.

---
 rtl/mips32_fetch_queue.sv | 112 +++++++++++
 tb/tb_mips32_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch queue feeding the MIPS32 IF/ID stage: issues word fetches,
// buffers returned words with their NPC, and flushes/refetches on a taken branch.
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk1,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  output logic          if_valid,
  output logic [31:0]   if_ir,
  output logic [31:0]   if_npc,
  input  logic          if_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } entry_t;

  entry_t        store [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;

  logic [CW:0]   in_use;
  logic          has_credit;
  logic          accept;
  logic          resp;
  logic          resp_drop;
  logic          push;
  logic          pop;

  // Buffered entries plus in-flight requests never exceed DEPTH, so a push
  // can never land on a full queue.
  assign in_use     = {1'b0, count} + {1'b0, outstanding};
  assign has_credit = in_use < (CW+1)'(DEPTH);

  assign imem_req  = !rst && !halt && !redirect_valid && has_credit;
  assign imem_addr = fetch_pc[AW-1:0];

  assign accept    = imem_req && imem_ready;
  assign resp      = imem_rvalid && (outstanding != '0);
  assign resp_drop = resp && (drop != '0);
  assign push      = resp && (drop == '0) && !redirect_valid;
  assign pop       = if_valid && if_ready && !redirect_valid;

  assign if_valid = (count != '0);
  assign if_ir    = if_valid ? store[head].ir  : 32'h0;
  assign if_npc   = if_valid ? store[head].npc : 32'h0;

  // NOTE: storage has no reset; outputs are gated by if_valid so stale contents never escape.
  always_ff @(posedge clk1) begin
    if (push) begin
      store[tail] <= '{ir: imem_rdata, npc: resp_pc + 32'd1};
    end
  end

  // NOTE: all state uses non-blocking assignments so every term reads pre-edge values.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (redirect_valid) begin
      // Every request still in flight belongs to the abandoned path.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      outstanding <= outstanding - CW'(resp);
      drop        <= outstanding - CW'(resp);
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd1;
      end
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (resp_drop) begin
        drop <= drop - CW'(1);
      end
      if (push) begin
        tail    <= tail + PW'(1);
        resp_pc <= resp_pc + 32'd1;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue with an in-order, fixed-latency memory
// model whose data word equals its word address.
module tb_mips32_fetch_queue;

  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          halt;
  logic          if_valid;
  logic [31:0]   if_ir;
  logic [31:0]   if_npc;
  logic          if_ready;

  int passed = 0;
  int total  = 0;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(.DEPTH(4), .AW(AW), .RESET_PC(32'h0)) dut (
    .clk1          (clk1),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .if_valid      (if_valid),
    .if_ir         (if_ir),
    .if_npc        (if_npc),
    .if_ready      (if_ready)
  );

  // Memory model: decisions on the falling edge take effect at the next rising edge.
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;

  req_t pend[$];
  int   cyc     = 0;
  int   lat     = 1;
  int   acc_cnt = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  always @(negedge clk1) begin
    if (rst) begin
      pend.delete();
      imem_rvalid <= 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= 32'(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
      if (imem_req && imem_ready) begin
        pend.push_back('{addr: imem_addr, due: cyc + 1 + lat});
        acc_cnt <= acc_cnt + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Waits (bounded) for a valid head, checks it, then lets the next edge pop it.
  task automatic expect_word(input string tag, input logic [31:0] ir, input logic [31:0] npc);
    int n = 0;
    while (!if_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_ir"}, if_ir, ir);
    check({tag, "_npc"}, if_npc, npc);
    tick();
  endtask

  initial begin
    int base;
    rst            = 1'b1;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    if_ready       = 1'b1;

    // Reset state
    repeat (2) @(posedge clk1);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_ir", if_ir, 32'h0);
    check("rst_npc", if_npc, 32'h0);

    // 1. Streaming, latency 1
    lat = 1;
    rst = 1'b0;
    #1;
    check("t1_first_req", 32'(imem_req), 32'd1);
    check("t1_first_addr", 32'(imem_addr), 32'h0);
    tick();
    check("t1_start_valid0", 32'(if_valid), 32'd0);
    tick();
    check("t1_valid", 32'(if_valid), 32'd1);
    check("t1_ir0", if_ir, 32'd0);
    check("t1_npc0", if_npc, 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t1_stream_valid", 32'(if_valid), 32'd1);
      check("t1_stream_ir", if_ir, 32'(i));
      check("t1_stream_npc", if_npc, 32'(i + 1));
    end

    // 2. Backpressure from empty
    if_ready = 1'b0;
    do_reset();
    base = acc_cnt;
    repeat (10) tick();
    check("t2_req_count", 32'(acc_cnt - base), 32'd4);
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_count", 32'(dut.count), 32'd4);
    check("t2_head_ir", if_ir, 32'd0);
    if_ready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      tick();
      check("t2_drain_valid", 32'(if_valid), 32'd1);
      check("t2_drain_ir", if_ir, 32'(i));
      check("t2_drain_npc", if_npc, 32'(i + 1));
    end

    // 3. Redirect with two requests in flight, latency 3
    lat = 3;
    do_reset();
    tick();
    tick();
    check("t3_outstanding", 32'(dut.outstanding), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check("t3_req_blocked", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t3_drop", 32'(dut.drop), 32'd2);
    check("t3_req_resume", 32'(imem_req), 32'd1);
    check("t3_addr_target", 32'(imem_addr), 32'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_no_stale", 32'(if_valid), 32'd0);
    end
    tick();
    check("t3_valid", 32'(if_valid), 32'd1);
    check("t3_ir", if_ir, 32'h40);
    check("t3_npc", if_npc, 32'h41);
    tick();
    expect_word("t3_w41", 32'h41, 32'h42);
    expect_word("t3_w42", 32'h42, 32'h43);
    expect_word("t3_w43", 32'h43, 32'h44);

    // 4. Redirect in the same cycle as a pop and a response, latency 2
    lat = 2;
    do_reset();
    repeat (3) tick();
    check("t4_pre_valid", 32'(if_valid), 32'd1);
    check("t4_pre_ir", if_ir, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_flush_valid", 32'(if_valid), 32'd0);
    check("t4_drop", 32'(dut.drop), 32'd1);
    check("t4_outstanding", 32'(dut.outstanding), 32'd1);
    tick();
    check("t4_drain_valid", 32'(if_valid), 32'd0);
    check("t4_drop_done", 32'(dut.drop), 32'd0);
    tick();
    check("t4_wait_valid", 32'(if_valid), 32'd0);
    tick();
    check("t4_valid", 32'(if_valid), 32'd1);
    check("t4_ir", if_ir, 32'h80);
    check("t4_npc", if_npc, 32'h81);
    tick();
    expect_word("t4_w81", 32'h81, 32'h82);
    expect_word("t4_w82", 32'h82, 32'h83);

    // 5. Halt mid-stream, latency 2
    lat = 2;
    do_reset();
    repeat (4) tick();
    check("t5_pre_ir", if_ir, 32'd1);
    halt = 1'b1;
    #1;
    check("t5_req_off", 32'(imem_req), 32'd0);
    base = acc_cnt;
    tick();
    check("t5_inflight_ir2", if_ir, 32'd2);
    tick();
    check("t5_inflight_ir3", if_ir, 32'd3);
    tick();
    check("t5_empty", 32'(if_valid), 32'd0);
    repeat (2) tick();
    check("t5_no_accepts", 32'(acc_cnt - base), 32'd0);
    check("t5_still_off", 32'(imem_req), 32'd0);
    halt = 1'b0;
    #1;
    check("t5_resume_req", 32'(imem_req), 32'd1);
    check("t5_resume_addr", 32'(imem_addr), 32'd4);
    expect_word("t5_w4", 32'd4, 32'd5);
    expect_word("t5_w5", 32'd5, 32'd6);

    // 6. Async reset between edges
    lat = 1;
    do_reset();
    repeat (3) tick();
    check("t6_pre_valid", 32'(if_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_req_fall", 32'(imem_req), 32'd0);
    check("t6_valid_fall", 32'(if_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_req_after", 32'(imem_req), 32'd1);
    check("t6_addr_after", 32'(imem_addr), 32'h0);
    tick();
    check("t6_start_valid0", 32'(if_valid), 32'd0);
    tick();
    check("t6_ir0", if_ir, 32'd0);
    check("t6_npc0", if_npc, 32'd1);

    // 7. PC wrap and address truncation
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t7_addr_trunc", 32'(imem_addr), 32'h3FF);
    expect_word("t7_wtop", 32'h3FF, 32'h0);
    expect_word("t7_wwrap", 32'h0, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
